// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin port arbiter.
// Requester ordering matches the mux input ordering of the port datapath.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      TURN = 2'd2
   } state_t;

   localparam logic [1:0] REQ_IF  = 2'd0;
   localparam logic [1:0] REQ_MEM = 2'd1;
   localparam logic [1:0] REQ_DBG = 2'd2;
   localparam logic [1:0] REQ_DMA = 2'd3;

   // Longest run of back-to-back locked transactions before a forced turnaround.
   localparam int LOCK_MAX = 8;

   // One-hot grant vector for a requester index.
   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      case (idx)
         REQ_IF:  return 4'b0001;
         REQ_MEM: return 4'b0010;
         REQ_DBG: return 4'b0100;
         REQ_DMA: return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   // True while another locked transaction may follow the current one.
   function automatic logic lock_room(input logic [3:0] run);
      return run < 4'(LOCK_MAX - 1);
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder: searches req upward from (last+1) mod 4 with wrap
// and returns the first set position.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic       any,
   output logic [1:0] idx
);

   logic [1:0] cand;

   // Scan from the farthest candidate back to the nearest so the nearest set bit wins.
   always_comb begin
      any  = |req;
      idx  = last;
      cand = last;
      for (int i = 4; i >= 1; i--) begin
         cand = last + 2'(i);
         if (req[cand]) idx = cand;
      end
   end

endmodule

// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter sharing one memory/bus port between IF, MEM, debug and DMA.
// Each transaction runs IDLE -> BUSY -> TURN; sel only moves on a grant edge so the
// 4:1 address/data mux is stable for the whole transaction.
// Optional feature: define ARB_LOCK_EN to add the lock input, which lets the
// winning requester chain up to LOCK_MAX transactions without a turnaround.
module rr_port_arbiter
   import arb_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TW      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
`ifdef ARB_LOCK_EN
   input  logic [3:0] lock,
`endif
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       bus_valid,
   input  logic       bus_ack,
   output logic [3:0] req_ack,
   output logic [3:0] req_err,
   output logic       busy
);

   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [1:0]    last_q, last_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    grant_q, grant_d;
   logic [3:0]    err_q, err_d;
   logic [TW-1:0] cnt_q, cnt_d;
`ifdef ARB_LOCK_EN
   logic [3:0]    run_q, run_d;
`endif

   logic          pick_any;
   logic [1:0]    pick_idx;

   rr_pick4 u_pick (
      .req  (req),
      .last (last_q),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   // Next-state, grant, timeout and error decisions for the transaction FSM.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      err_d   = '0;
`ifdef ARB_LOCK_EN
      run_d   = run_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = onehot4(pick_idx);
               sel_d   = pick_idx;
               last_d  = pick_idx;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (bus_ack) begin
`ifdef ARB_LOCK_EN
               if (lock[sel_q] && lock_room(run_q)) begin
                  cnt_d = '0;
                  run_d = run_q + 1'b1;
               end else begin
                  grant_d = '0;
                  run_d   = '0;
                  state_d = TURN;
               end
`else
               grant_d = '0;
               state_d = TURN;
`endif
            end else if (!req[sel_q]) begin
               // Requester gave up; drop the transaction without ack or error.
               grant_d = '0;
               state_d = TURN;
`ifdef ARB_LOCK_EN
               run_d   = '0;
`endif
            end else if (cnt_q == TO_LAST) begin
               err_d   = grant_q;
               grant_d = '0;
               state_d = TURN;
`ifdef ARB_LOCK_EN
               run_d   = '0;
`endif
            end
         end
         TURN: begin
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath-select registers; last winner resets to DMA so IF wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= REQ_DMA;
         sel_q   <= REQ_IF;
         grant_q <= '0;
         err_q   <= '0;
         cnt_q   <= '0;
`ifdef ARB_LOCK_EN
         run_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`ifdef ARB_LOCK_EN
         run_q   <= run_d;
`endif
      end
   end

   assign grant     = grant_q;
   assign sel       = sel_q;
   assign bus_valid = (state_q == BUSY);
   assign busy      = (state_q != IDLE);
   assign req_err   = err_q;
   assign req_ack   = grant_q & {4{bus_ack & bus_valid}};

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed bench for rr_port_arbiter: stimulus pushes expected grant/ack/error
// events with their cycle stamps; a negedge monitor pops and compares them.
module tb_rr_port_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       bus_ack = 1'b0;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       bus_valid;
   logic [3:0] req_ack;
   logic [3:0] req_err;
   logic       busy;
`ifdef ARB_LOCK_EN
   logic [3:0] lock = 4'b0000;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      byte        kind;
      logic [5:0] val;
      int         at;
   } evt_t;

   evt_t exq[$];
   logic [3:0] prev_grant = 4'b0000;

   rr_port_arbiter #(.TIMEOUT(16), .TW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
`ifdef ARB_LOCK_EN
      .lock      (lock),
`endif
      .grant     (grant),
      .sel       (sel),
      .bus_valid (bus_valid),
      .bus_ack   (bus_ack),
      .req_ack   (req_ack),
      .req_err   (req_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic expect_evt(input byte k, input logic [5:0] v, input int at);
      evt_t e;
      e.kind = k;
      e.val  = v;
      e.at   = at;
      exq.push_back(e);
   endtask

   task automatic see(input byte k, input logic [5:0] v);
      evt_t e;
      total++;
      if (exq.size() == 0) begin
         bad++;
         $display("FAIL unexpected_%c: got %0h at cycle %0d, expected no event", k, v, cyc);
      end else begin
         e = exq.pop_front();
         if (e.kind != k || e.val != v || e.at != cyc) begin
            bad++;
            $display("FAIL event_%c: got %c/%0h at cycle %0d expected %c/%0h at cycle %0d",
                     e.kind, k, v, cyc, e.kind, e.val, e.at);
         end
      end
   endtask

   // Monitor: grant rising edge (with sel), ack pulses and error pulses.
   always @(negedge clk) begin
      if (!rst) begin
         if (grant != 4'b0000 && prev_grant == 4'b0000) see("G", {sel, grant});
         if (req_ack != 4'b0000) see("A", {2'b00, req_ack});
         if (req_err != 4'b0000) see("E", {2'b00, req_err});
      end
      prev_grant <= grant;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      tick();
      tick();
      chk("rst_grant", {28'd0, grant}, 32'd0);
      chk("rst_sel", {30'd0, sel}, 32'd0);
      chk("rst_valid", {31'd0, bus_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {28'd0, req_err}, 32'd0);
      rst = 1'b0;

      // T1: single IF request, ack on 3rd BUSY cycle
      req = 4'b0001;
      expect_evt("G", {2'd0, 4'b0001}, cyc + 1);
      tick();
      tick();
      tick();
      bus_ack = 1'b1;
      expect_evt("A", 6'b000001, cyc);
      tick();
      bus_ack = 1'b0;
      req = 4'b0000;
      chk("t1_turn_grant", {28'd0, grant}, 32'd0);
      chk("t1_turn_valid", {31'd0, bus_valid}, 32'd0);
      chk("t1_turn_busy", {31'd0, busy}, 32'd1);
      chk("t1_turn_sel", {30'd0, sel}, 32'd0);
      tick();
      chk("t1_idle_busy", {31'd0, busy}, 32'd0);

      // T2: all four requesting after a reset -> 0,1,2,3,0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b1111;
      expect_evt("G", {2'd0, 4'b0001}, cyc + 1);
      for (int k = 0; k < 5; k++) begin
         tick();
         tick();
         bus_ack = 1'b1;
         expect_evt("A", {2'b00, 4'b0001 << (k % 4)}, cyc);
         tick();
         bus_ack = 1'b0;
         chk("t2_turn_grant", {28'd0, grant}, 32'd0);
         chk("t2_turn_sel", {30'd0, sel}, 32'(k % 4));
         if (k < 4) expect_evt("G", {2'((k + 1) % 4), 4'b0001 << ((k + 1) % 4)}, cyc + 2);
         else req = 4'b0000;
         tick();
      end
      chk("t2_idle_busy", {31'd0, busy}, 32'd0);

      // T3: debug request, no ack -> 16 cycles of bus_valid then timeout error
      req = 4'b0100;
      expect_evt("G", {2'd2, 4'b0100}, cyc + 1);
      tick();
      expect_evt("E", 6'b000100, cyc + 16);
      n = 0;
      while (bus_valid && n < 40) begin
         n++;
         tick();
      end
      req = 4'b0000;
      chk("t3_valid_cycles", 32'(n), 32'd16);
      chk("t3_turn_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("t3_idle_busy", {31'd0, busy}, 32'd0);

      // T4: MEM request dropped on 3rd BUSY cycle, late ack ignored
      req = 4'b0010;
      expect_evt("G", {2'd1, 4'b0010}, cyc + 1);
      tick();
      tick();
      tick();
      req = 4'b0000;
      tick();
      chk("t4_abort_grant", {28'd0, grant}, 32'd0);
      chk("t4_abort_valid", {31'd0, bus_valid}, 32'd0);
      bus_ack = 1'b1;
      #1;
      chk("t4_late_ack", {28'd0, req_ack}, 32'd0);
      tick();
      bus_ack = 1'b0;
      chk("t4_idle_busy", {31'd0, busy}, 32'd0);

      // T5: reset during debug transaction, then DMA request
      req = 4'b0100;
      expect_evt("G", {2'd2, 4'b0100}, cyc + 1);
      tick();
      tick();
      chk("t5_sel_before", {30'd0, sel}, 32'd2);
      #2;
      rst = 1'b1;
      req = 4'b0000;
      #1;
      chk("t5_rst_grant", {28'd0, grant}, 32'd0);
      chk("t5_rst_sel", {30'd0, sel}, 32'd0);
      chk("t5_rst_valid", {31'd0, bus_valid}, 32'd0);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      tick();
      rst = 1'b0;
      req = 4'b1000;
      expect_evt("G", {2'd3, 4'b1000}, cyc + 1);
      tick();
      bus_ack = 1'b1;
      expect_evt("A", 6'b001000, cyc);
      tick();
      bus_ack = 1'b0;
      req = 4'b0000;
      tick();

      // T6: ack coincides with the timeout cycle -> ack, no error
      req = 4'b0001;
      expect_evt("G", {2'd0, 4'b0001}, cyc + 1);
      tick();
      repeat (15) tick();
      chk("t6_still_valid", {31'd0, bus_valid}, 32'd1);
      bus_ack = 1'b1;
      expect_evt("A", 6'b000001, cyc);
      tick();
      bus_ack = 1'b0;
      req = 4'b0000;
      chk("t6_turn_valid", {31'd0, bus_valid}, 32'd0);
      tick();
      tick();

`ifdef ARB_LOCK_EN
      // Locked DMA burst: 8 acks without turnaround, forced TURN, regrant
      req  = 4'b1000;
      lock = 4'b1000;
      expect_evt("G", {2'd3, 4'b1000}, cyc + 1);
      tick();
      for (int a = 0; a < 8; a++) begin
         bus_ack = 1'b1;
         expect_evt("A", 6'b001000, cyc);
         tick();
      end
      bus_ack = 1'b0;
      chk("lk_forced_turn", {31'd0, bus_valid}, 32'd0);
      expect_evt("G", {2'd3, 4'b1000}, cyc + 2);
      tick();
      tick();
      bus_ack = 1'b1;
      expect_evt("A", 6'b001000, cyc);
      tick();
      chk("lk_still_busy", {31'd0, bus_valid}, 32'd1);
      lock = 4'b0000;
      expect_evt("A", 6'b001000, cyc);
      tick();
      bus_ack = 1'b0;
      req = 4'b0000;
      chk("lk_release", {31'd0, bus_valid}, 32'd0);
      tick();
      tick();
`endif

      tick();
      chk("queue_drained", 32'(exq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
